// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and FSM state type for alu_pipe.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_SRA = 4'h8;
  localparam logic [3:0] OP_INC = 4'h9;
  localparam logic [3:0] OP_DEC = 4'hA;
  localparam logic [3:0] OP_MOV = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_NEG   = 2;
  localparam int FLG_OVF   = 3;
  localparam int FLG_ERR   = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle.
// done is high during the final step; prod_lo/hi_nz then show that step's outcome.
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic             hi_nz
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] mplier_nxt;

  // Multiplier bits retire from the bottom while product bits enter from the top.
  assign addend     = mplier[0] ? mcand : '0;
  assign sum        = {1'b0, acc} + {1'b0, addend};
  assign acc_nxt    = sum[WIDTH:1];
  assign mplier_nxt = {sum[0], mplier[WIDTH-1:1]};

  assign done    = (cnt == CW'(1));
  assign prod_lo = mplier_nxt;
  assign hi_nz   = |acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= a;
      acc    <= '0;
      mplier <= b;
      cnt    <= CW'(WIDTH);
    end else if (cnt != '0) begin
      acc    <= acc_nxt;
      mplier <= mplier_nxt;
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes and an iterative multiply.
// state   | meaning
// ST_IDLE | accepting ops; single-cycle results load the output register directly
// ST_MUL  | multiplier stepping; input stalled until the last step lands the result
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);

  state_t state, state_nxt;

  logic             accept;
  logic             is_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_lo;
  logic             mul_hi_nz;

  logic [WIDTH-1:0] op2;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w, sra_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry, alu_ovf, alu_err;
  logic [4:0]       alu_flags;
  logic [4:0]       mul_flags;

  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (s == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .prod_lo (mul_lo),
    .hi_nz   (mul_hi_nz)
  );

  // Extra bit on each shift result catches the last bit shifted out (0 for amount 0).
  assign op2   = (s == OP_INC || s == OP_DEC) ? WIDTH'(1) : b;
  assign sh    = b[SHW-1:0];
  assign add_w = {1'b0, a} + {1'b0, op2};
  assign sub_w = {1'b0, a} - {1'b0, op2};
  assign shl_w = {1'b0, a} << sh;
  assign shr_w = {a, 1'b0} >> sh;
  assign sra_w = $unsigned($signed({a, 1'b0}) >>> sh);

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    case (s)
      OP_ADD, OP_INC: begin
        alu_res   = add_w[WIDTH-1:0];
        alu_carry = add_w[WIDTH];
        alu_ovf   = (a[WIDTH-1] == op2[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_DEC: begin
        alu_res   = sub_w[WIDTH-1:0];
        alu_carry = ~sub_w[WIDTH];
        alu_ovf   = (a[WIDTH-1] != op2[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      OP_SHL: begin
        alu_res   = shl_w[WIDTH-1:0];
        alu_carry = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_res   = shr_w[WIDTH:1];
        alu_carry = shr_w[0];
      end
      OP_SRA: begin
        alu_res   = sra_w[WIDTH:1];
        alu_carry = sra_w[0];
      end
      OP_MOV: alu_res = b;
      OP_MUL: alu_res = '0;
      default: alu_err = 1'b1;
    endcase

    alu_flags            = '0;
    alu_flags[FLG_ZERO]  = (alu_res == '0);
    alu_flags[FLG_CARRY] = alu_carry;
    alu_flags[FLG_NEG]   = alu_res[WIDTH-1];
    alu_flags[FLG_OVF]   = alu_ovf;
    alu_flags[FLG_ERR]   = alu_err;
    if (alu_err) begin
      alu_flags           = '0;
      alu_flags[FLG_ERR]  = 1'b1;
      alu_flags[FLG_ZERO] = 1'b1;
    end
  end

  always_comb begin
    mul_flags            = '0;
    mul_flags[FLG_ZERO]  = (mul_lo == '0);
    mul_flags[FLG_CARRY] = mul_hi_nz;
    mul_flags[FLG_NEG]   = mul_lo[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && is_mul) state_nxt = ST_MUL;
      ST_MUL:  if (mul_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (accept && !is_mul) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      flags     <= alu_flags;
    end else if (state == ST_MUL && mul_done) begin
      out_valid <= 1'b1;
      result    <= mul_lo;
      flags     <= mul_flags;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=16 with hand-computed results and flags.
module tb_alu_pipe;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  s;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [4:0]  flags;

  int errors = 0;
  int checks = 0;

  alu_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one op at a negedge; it transfers on the following posedge.
  task automatic single(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic [3:0] ts, input logic [15:0] er, input logic [4:0] ef);
    a = ta; b = tb; s = ts; in_valid = 1'b1;
    #1 chk({tag, " in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, " out_valid"}, out_valid, 1);
    chk({tag, " result"}, result, er);
    chk({tag, " flags"}, flags, ef);
  endtask

  task automatic mul_run(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                         input logic [15:0] er, input logic [4:0] ef);
    int cyc;
    a = ta; b = tb; s = OP_MUL; in_valid = 1'b1;
    #1 chk({tag, " in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, " busy in_ready"}, in_ready, 0);
    chk({tag, " busy out_valid"}, out_valid, 0);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, cyc, 16);
    chk({tag, " result"}, result, er);
    chk({tag, " flags"}, flags, ef);
    chk({tag, " in_ready at done"}, in_ready, 1);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; s = '0;
    repeat (2) @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset result", result, 0);
    chk("reset flags", flags, 0);
    rst_n = 1'b1;
    #1 chk("post-reset in_ready", in_ready, 1);
    @(negedge clk);

    single("ADD", 16'h0004, 16'h0005, OP_ADD, 16'h0009, 5'b00000);
    single("SUB", 16'h0004, 16'h0005, OP_SUB, 16'hFFFF, 5'b00100);
    single("AND", 16'h0004, 16'h0005, OP_AND, 16'h0004, 5'b00000);
    single("OR",  16'h0004, 16'h0005, OP_OR,  16'h0005, 5'b00000);
    single("XOR", 16'h0004, 16'h0005, OP_XOR, 16'h0001, 5'b00000);
    single("NOT", 16'h0004, 16'h0005, OP_NOT, 16'hFFFB, 5'b00100);
    single("SHL", 16'h0004, 16'h0005, OP_SHL, 16'h0080, 5'b00000);
    single("SHR", 16'h0004, 16'h0005, OP_SHR, 16'h0000, 5'b00001);
    single("SRA", 16'h0004, 16'h0005, OP_SRA, 16'h0000, 5'b00001);
    single("INC", 16'h0004, 16'h0005, OP_INC, 16'h0005, 5'b00000);
    single("DEC", 16'h0004, 16'h0005, OP_DEC, 16'h0003, 5'b00010);
    single("MOV", 16'h0004, 16'h0005, OP_MOV, 16'h0005, 5'b00000);
    mul_run("MUL 4*5", 16'h0004, 16'h0005, 16'h0014, 5'b00000);

    single("ADD ovf", 16'h7FFF, 16'h0001, OP_ADD, 16'h8000, 5'b01100);
    single("INC wrap", 16'hFFFF, 16'h0001, OP_INC, 16'h0000, 5'b00011);
    single("SRA by 1", 16'h8001, 16'h0001, OP_SRA, 16'hC000, 5'b00110);
    single("SRA by 0", 16'h8001, 16'h0000, OP_SRA, 16'h8001, 5'b00100);
    single("SHL by 15", 16'h0003, 16'h000F, OP_SHL, 16'h8000, 5'b00110);
    single("SUB ovf", 16'h8000, 16'h0001, OP_SUB, 16'h7FFF, 5'b01010);
    single("illegal D", 16'h1234, 16'h5678, 4'hD, 16'h0000, 5'b10001);
    single("illegal F", 16'hFFFF, 16'hFFFF, 4'hF, 16'h0000, 5'b10001);

    @(negedge clk);
    out_ready = 1'b0;
    a = 16'h0001; b = 16'h0002; s = OP_ADD; in_valid = 1'b1;
    @(negedge clk);
    chk("bp first valid", out_valid, 1);
    chk("bp first result", result, 16'h0003);
    a = 16'h0003; b = 16'h0004;
    #1 chk("bp in_ready low", in_ready, 0);
    repeat (3) @(negedge clk);
    chk("bp held valid", out_valid, 1);
    chk("bp held result", result, 16'h0003);
    chk("bp held flags", flags, 5'b00000);
    chk("bp still stalled", in_ready, 0);
    out_ready = 1'b1;
    #1 chk("bp release in_ready", in_ready, 1);
    @(negedge clk);
    chk("bp second valid", out_valid, 1);
    chk("bp second result", result, 16'h0007);
    a = 16'h0005; b = 16'h0006;
    @(negedge clk);
    chk("bp third result", result, 16'h000B);
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain out_valid", out_valid, 0);

    a = 16'h0100; b = 16'h0100; s = OP_MUL; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", out_valid, 0);
    chk("abort result", result, 0);
    chk("abort flags", flags, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (24) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("aborted MUL silent", seen, 0);
    chk("idle after abort", in_ready, 1);
    mul_run("MUL 100*100", 16'h0100, 16'h0100, 16'h0000, 5'b00011);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
